character_object_sequencer: RTL and testbench

- Runtime-side initiator for the character object ROM handshake: drives the ROM address and sync_character, and consumes update_character and the decoded character_pos_x/y/index.
- Walks the character script entry by entry and holds each entry for a fixed number of frames.
- Glides the displayed character position toward each entry's target at a bounded per-frame step.
- Feeds the render/collision path with a stable char_x/char_y/char_index/char_valid.

---
 rtl/character_object_sequencer_pkg.sv | 14 +
 rtl/character_pos_stepper.sv | 22 ++
 rtl/character_object_sequencer.sv | 159 +++++++++++++++
 tb/tb_character_object_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/character_object_sequencer_pkg.sv
// Shared types for the character object sequencer: state encoding, position
// width and the default end-of-script sprite index.
package character_object_sequencer_pkg;
  localparam int POS_W = 10;
  localparam logic [7:0] END_INDEX_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_CHECK = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;
endpackage

// File: rtl/character_pos_stepper.sv
// One axis of the glide: moves cur toward tgt by at most step when enabled,
// using unsigned compares so the result never wraps past the target.
module character_pos_stepper
  import character_object_sequencer_pkg::*;
(
  input  logic [POS_W-1:0] cur_i,
  input  logic [POS_W-1:0] tgt_i,
  input  logic [POS_W-1:0] step_i,
  input  logic             en_i,
  output logic [POS_W-1:0] nxt_o,
  output logic             at_tgt_o
);
  always_comb begin
    nxt_o = cur_i;
    if (en_i) begin
      if (cur_i < tgt_i) nxt_o = ((tgt_i - cur_i) > step_i) ? cur_i + step_i : tgt_i;
      else               nxt_o = ((cur_i - tgt_i) > step_i) ? cur_i - step_i : tgt_i;
    end
  end

  assign at_tgt_o = (nxt_o == tgt_i);
endmodule

// File: rtl/character_object_sequencer.sv
// Walks the character script through the ROM reader handshake, holds each
// entry for HOLD_FRAMES frames and glides the sprite toward each target.
// Define CHAR_SEQ_LOOP_EN to restart the script instead of stopping in DONE.
module character_object_sequencer
  import character_object_sequencer_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 10,
  parameter int         HOLD_FRAMES = 60,
  parameter int         STEP_PX     = 4,
  parameter logic [7:0] END_INDEX   = END_INDEX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  frame_tick,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  sync_character,
  input  logic                  update_character,
  input  logic [POS_W-1:0]      character_pos_x,
  input  logic [POS_W-1:0]      character_pos_y,
  input  logic [7:0]            character_index,
  output logic [POS_W-1:0]      char_x,
  output logic [POS_W-1:0]      char_y,
  output logic [7:0]            char_index,
  output logic                  char_valid,
  output logic                  seq_done
);
  localparam int               CNT_W    = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_FRAMES);
  localparam logic [POS_W-1:0] STEP     = POS_W'(STEP_PX);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  sync_q, sync_d;
  logic [POS_W-1:0]      x_q, x_d, y_q, y_d, tx_q, tx_d, ty_q, ty_d;
  logic [7:0]            idx_q, idx_d, tidx_q, tidx_d;
  logic                  valid_q, valid_d, done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [POS_W-1:0]      x_nxt, y_nxt;
  logic                  x_at, y_at, step_en;

  assign step_en = (state_q == S_HOLD) && frame_tick;

  character_pos_stepper u_step_x (
    .cur_i(x_q), .tgt_i(tx_q), .step_i(STEP), .en_i(step_en), .nxt_o(x_nxt), .at_tgt_o(x_at)
  );
  character_pos_stepper u_step_y (
    .cur_i(y_q), .tgt_i(ty_q), .step_i(STEP), .en_i(step_en), .nxt_o(y_nxt), .at_tgt_o(y_at)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sync_d  = sync_q;
    x_d     = x_q;
    y_d     = y_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    idx_d   = idx_q;
    tidx_d  = tidx_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_REQ;
        sync_d  = update_character;  // never request while the reader still flags old data
      end
      S_REQ: begin
        if (!sync_q && update_character) begin
          tx_d    = character_pos_x;
          ty_d    = character_pos_y;
          tidx_d  = character_index;
          sync_d  = 1'b1;
          state_d = S_CHECK;
        end else if (sync_q && !update_character) begin
          sync_d = 1'b0;
        end
      end
      S_CHECK: begin
        if (tidx_q == END_INDEX || addr_q == '1) begin
`ifdef CHAR_SEQ_LOOP_EN
          addr_d  = '0;
          sync_d  = update_character;
          done_d  = 1'b1;
          state_d = S_REQ;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d = tidx_q;
          cnt_d = '0;
          if (!valid_q) begin
            x_d     = tx_q;
            y_d     = ty_q;
            valid_d = 1'b1;
          end
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // A tick on the exit cycle is applied before the exit test below.
        x_d = x_nxt;
        y_d = y_nxt;
        if (frame_tick && cnt_q != HOLD_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == HOLD_MAX && x_at && y_at && !update_character) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          sync_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DONE: if (start) begin
        addr_d  = '0;
        sync_d  = update_character;
        state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = done_d | (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sync_q  <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      idx_q   <= '0;
      tidx_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sync_q  <= sync_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      idx_q   <= idx_d;
      tidx_q  <= tidx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign addr           = addr_q;
  assign sync_character = sync_q;
  assign char_x         = x_q;
  assign char_y         = y_q;
  assign char_index     = idx_q;
  assign char_valid     = valid_q;
  assign seq_done       = done_q;
endmodule

// File: tb/tb_character_object_sequencer.sv
// Directed + randomized bench for character_object_sequencer with a
// behavioural ROM reader and a transaction-level glide model.
module tb_character_object_sequencer;
  localparam int AW = 3;
  localparam int HF = 2;
  localparam int SP = 4;
  localparam int NENT = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, frame_tick;
  logic [AW-1:0] addr;
  logic          sync, upd;
  logic [9:0]    px, py, cx, cy;
  logic [7:0]    pidx, cidx;
  logic          cval, done;

  int lat, xtra, wcnt, hcnt;
  int rom_x[NENT], rom_y[NENT], rom_i[NENT];
  int cur_x, cur_y, cur_idx;
  bit mvalid;
  int n_chk, n_err;

  character_object_sequencer #(
    .ADDR_WIDTH(AW), .HOLD_FRAMES(HF), .STEP_PX(SP), .END_INDEX(8'hFF)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .frame_tick(frame_tick),
    .addr(addr), .sync_character(sync), .update_character(upd),
    .character_pos_x(px), .character_pos_y(py), .character_index(pidx),
    .char_x(cx), .char_y(cy), .char_index(cidx), .char_valid(cval), .seq_done(done)
  );

  always #5 clk = ~clk;

  // ROM reader: raises update lat cycles after sync falls, drops it xtra
  // cycles after sync returns high.
  initial begin
    upd = 1'b0; px = '0; py = '0; pidx = '0; wcnt = 0; hcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        upd = 1'b0; wcnt = 0; hcnt = 0;
      end else if (!upd) begin
        hcnt = 0;
        if (!sync) begin
          wcnt++;
          if (wcnt >= lat) begin
            upd  = 1'b1;
            px   = 10'(rom_x[addr]);
            py   = 10'(rom_y[addr]);
            pidx = 8'(rom_i[addr]);
            wcnt = 0;
          end
        end else wcnt = 0;
      end else if (sync) begin
        if (hcnt >= xtra) upd = 1'b0;
        else hcnt++;
      end
    end
  end

  function automatic int step_to(input int c, input int t);
    int d;
    d = (t > c) ? t - c : c - t;
    if (d > SP) d = SP;
    return (t > c) ? c + d : c - d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur_x = 0; cur_y = 0; cur_idx = 0; mvalid = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic tick();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic fill_rom(input bit endless_idx);
    for (int i = 0; i < NENT; i++) begin
      rom_x[i] = $urandom_range(0, 1023);
      rom_y[i] = $urandom_range(0, 1023);
      rom_i[i] = endless_idx ? $urandom_range(0, 254) : 255;
    end
  endtask

  task automatic load_entry(input int a, input bit is_end);
    int n;
    n = 0;
    while (sync !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    chk("req_sync_low", 32'(sync), 0);
    chk("req_addr", 32'(addr), 32'(a));
    n = 0;
    while (sync !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("ack_sync_high", 32'(sync), 1);
    @(negedge clk);
    if (is_end) begin
`ifdef CHAR_SEQ_LOOP_EN
      chk("loop_done_pulse", 32'(done), 1);
      chk("loop_addr", 32'(addr), 0);
      @(negedge clk);
      chk("loop_done_clear", 32'(done), 0);
`else
      chk("end_done", 32'(done), 1);
      chk("end_sync", 32'(sync), 1);
      chk("end_addr", 32'(addr), 32'(a));
`endif
      chk("end_x", 32'(cx), 32'(cur_x));
      chk("end_y", 32'(cy), 32'(cur_y));
      chk("end_idx", 32'(cidx), 32'(cur_idx));
    end else begin
      if (!mvalid) begin cur_x = rom_x[a]; cur_y = rom_y[a]; mvalid = 1; end
      cur_idx = rom_i[a];
      chk("load_idx", 32'(cidx), 32'(cur_idx));
      chk("load_x", 32'(cx), 32'(cur_x));
      chk("load_y", 32'(cy), 32'(cur_y));
      chk("load_valid", 32'(cval), 1);
      chk("load_done", 32'(done), 0);
    end
  endtask

  task automatic hold_entry(input int a);
    int  n;
    bit  ex;
    repeat (4) @(negedge clk);
    n = 0; ex = 0;
    while (!ex && n < 400) begin
      tick();
      n++;
      cur_x = step_to(cur_x, rom_x[a]);
      cur_y = step_to(cur_y, rom_y[a]);
      chk("glide_x", 32'(cx), 32'(cur_x));
      chk("glide_y", 32'(cy), 32'(cur_y));
      if (n >= HF && cur_x == rom_x[a] && cur_y == rom_y[a]) begin
        ex = 1;
        chk("next_addr", 32'(addr), 32'((a + 1) % NENT));
        chk("next_sync", 32'(sync), 0);
      end else begin
        chk("hold_addr", 32'(addr), 32'(a));
      end
    end
  endtask

  initial begin
    int n;
    n_chk = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; frame_tick = 1'b0; lat = 2; xtra = 0;
    model_reset();
    fill_rom(1);
    rom_x[0] = 100; rom_y[0] = 200; rom_i[0] = 3;
    rom_x[1] = 110; rom_y[1] = 190; rom_i[1] = 5;
    rom_x[2] = 0;   rom_y[2] = 0;   rom_i[2] = 255;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_sync", 32'(sync), 1);
    chk("rst_x", 32'(cx), 0);
    chk("rst_y", 32'(cy), 0);
    chk("rst_idx", 32'(cidx), 0);
    chk("rst_valid", 32'(cval), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed script: snap, glide, end marker, restart under a sticky reader.
    pulse_start();
    load_entry(0, 0);
    hold_entry(0);
    load_entry(1, 0);
    hold_entry(1);
    xtra = 3;
    load_entry(2, 1);
`ifndef CHAR_SEQ_LOOP_EN
    pulse_start();
    chk("restart_sync_held", 32'(sync), 1);
    n = 0;
    while (upd === 1'b1 && n < 20) begin
      chk("sync_wait_upd", 32'(sync), 1);
      @(negedge clk);
      n++;
    end
    chk("upd_drop", 32'(upd), 0);
    @(negedge clk);
    chk("restart_sync", 32'(sync), 0);
    chk("restart_addr", 32'(addr), 0);
`endif
    load_entry(0, 0);
    hold_entry(0);

    // Random script, reset asserted asynchronously in the middle of HOLD.
    @(negedge clk);
    rst = 1'b1;
    lat = $urandom_range(1, 3); xtra = $urandom_range(0, 3);
    fill_rom(1);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    for (int a = 0; a < 5; a++) begin
      load_entry(a, 0);
      hold_entry(a);
    end
    load_entry(5, 0);
    repeat (4) @(negedge clk);
    tick();
    chk("mid_hold_addr", 32'(addr), 5);
    #2 rst = 1'b1;
    #1 chk("async_rst_addr", 32'(addr), 0);
    @(negedge clk);
    model_reset();
    chk("mhr_addr", 32'(addr), 0);
    chk("mhr_sync", 32'(sync), 1);
    chk("mhr_valid", 32'(cval), 0);
    chk("mhr_done", 32'(done), 0);
    chk("mhr_x", 32'(cx), 0);
    chk("mhr_idx", 32'(cidx), 0);

    // Random script with no end marker: the last address ends the script.
    lat = $urandom_range(1, 3); xtra = $urandom_range(0, 3);
    fill_rom(1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    for (int a = 0; a < NENT - 1; a++) begin
      load_entry(a, 0);
      hold_entry(a);
    end
    load_entry(NENT - 1, 1);
`ifndef CHAR_SEQ_LOOP_EN
    repeat (3) @(negedge clk);
    chk("done_stable", 32'(done), 1);
    chk("done_sync_stable", 32'(sync), 1);
    chk("done_x_stable", 32'(cx), 32'(cur_x));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
